rr_priority_encoder: RTL and testbench

Registered 16-to-4 round-robin priority encoder; the inverse of the team's 4-to-16 one-hot decoder. Samples a 16-bit request vector and emits the binary index of one asserted bit, plus its one-hot grant, through a valid/ready output register. A rotating priority pointer keeps persistent requesters from starving. Sits in front of decoder-driven select logic, where its index feeds back to the requester side.

---
 rtl/encoder_pkg.sv | 25 ++
 rtl/rr_pick_first.sv | 37 +++
 rtl/rr_priority_encoder.sv | 96 +++++++++
 tb/tb_rr_priority_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the round-robin priority encoder.
//   WIDTH  : number of request lines (power of two, >= 2)
//   IDX_W  : index width, $clog2(WIDTH)
//   idx_t  : request index
//   req_t  : request / grant vector
//   state_t: output register occupancy
package encoder_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [WIDTH-1:0] req_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // One-hot vector with only bit idx set.
    function automatic req_t onehot(input idx_t idx);
        return req_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Combinational rotating find-first.
//   req   : request vector
//   start : index with highest priority; search wraps past WIDTH-1 to 0
//   idx   : first set bit at or after start (mod WIDTH)
//   found : at least one request set
//   multi : more than one request set
module rr_pick_first
    import encoder_pkg::*;
(
    input  req_t req,
    input  idx_t start,
    output idx_t idx,
    output logic found,
    output logic multi
);

    req_t             lo_mask;
    logic [2*WIDTH-1:0] search;

    // Lower copy drops bits below start; the upper copy provides the wrap.
    always_comb begin
        lo_mask = {WIDTH{1'b1}} << start;
        search  = {req, req & lo_mask};
        idx     = '0;
        // Descending scan so the lowest set position is the last one written.
        for (int i = 2 * WIDTH - 1; i >= 0; i--) begin
            if (search[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign found = |req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(req & (req - req_t'(1)));

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered 16-to-4 round-robin priority encoder with valid/ready output.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   enable     : capture enable (does not affect a pending output)
//   encoder_in : level request vector
//   out_ready  : downstream accepts current output
//   out_valid  : outputs below are valid
//   binary_out : index of the granted request
//   grant_out  : one-hot of binary_out, zero when not valid
//   multi_hot  : more than one request was set at capture
module rr_priority_encoder
    import encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  req_t       encoder_in,
    input  logic       out_ready,
    output logic       out_valid,
    output idx_t       binary_out,
    output req_t       grant_out,
    output logic       multi_hot
);

    state_t state_q;
    idx_t   ptr_q,   ptr_d;
    idx_t   bin_q;
    req_t   grant_q;
    logic   multi_q;

    logic   accept;
    logic   load;
    logic   capture;
    idx_t   pick_idx;
    logic   pick_found;
    logic   pick_multi;

    assign out_valid  = (state_q == FULL);
    assign binary_out = bin_q;
    assign grant_out  = grant_q;
    assign multi_hot  = multi_q;

    // Handshake; on accept the search already starts past the departing grant.
    always_comb begin
        accept  = out_valid && out_ready;
        load    = !out_valid || out_ready;
        ptr_d   = accept ? IDX_W'(bin_q + idx_t'(1)) : ptr_q;
        capture = load && enable && pick_found;
    end

    rr_pick_first u_pick (
        .req   (encoder_in),
        .start (ptr_d),
        .idx   (pick_idx),
        .found (pick_found),
        .multi (pick_multi)
    );

    // Occupancy FSM and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            bin_q   <= '0;
            grant_q <= '0;
            multi_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            case (state_q)
                EMPTY: begin
                    if (capture) begin
                        state_q <= FULL;
                        bin_q   <= pick_idx;
                        grant_q <= onehot(pick_idx);
                        multi_q <= pick_multi;
                    end
                end
                FULL: begin
                    if (capture) begin
                        bin_q   <= pick_idx;
                        grant_q <= onehot(pick_idx);
                        multi_q <= pick_multi;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench for rr_priority_encoder: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_rr_priority_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] encoder_in;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  binary_out;
    logic [15:0] grant_out;
    logic        multi_hot;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit m_valid;
    int m_bin;
    int m_ptr;
    bit m_multi;

    always #5 clk = ~clk;

    rr_priority_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .encoder_in (encoder_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .binary_out (binary_out),
        .grant_out  (grant_out),
        .multi_hot  (multi_hot)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One rising edge of the behavioural model, using the inputs the DUT saw.
    task automatic model_update();
        int ones;
        bit taken;
        if (reset) begin
            m_valid = 0; m_bin = 0; m_ptr = 0; m_multi = 0;
        end else begin
            bit load;
            load = !m_valid || out_ready;
            if (m_valid && out_ready) m_ptr = (m_bin + 1) % 16;
            if (load) begin
                if (enable && encoder_in != 0) begin
                    taken = 0;
                    for (int k = 0; k < 16; k++) begin
                        int j;
                        j = (m_ptr + k) % 16;
                        if (!taken && encoder_in[j]) begin
                            m_bin = j;
                            taken = 1;
                        end
                    end
                    ones = 0;
                    for (int k = 0; k < 16; k++) ones += encoder_in[k];
                    m_multi = (ones > 1);
                    m_valid = 1;
                end else begin
                    m_valid = 0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [15:0] eg;
        eg = m_valid ? (16'h1 << m_bin) : 16'h0;
        check_eq("valid", 32'(out_valid), 32'(m_valid));
        check_eq("grant", 32'(grant_out), 32'(eg));
        if (m_valid) begin
            check_eq("binary", 32'(binary_out), 32'(m_bin));
            check_eq("multi", 32'(multi_hot), 32'(m_multi));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    initial begin
        int prev;
        // 1. reset with all requests set
        reset = 1; enable = 1; encoder_in = 16'hFFFF; out_ready = 1;
        step(); step();
        check_eq("t1_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t1_rst_grant", 32'(grant_out), 32'd0);
        reset = 0;
        step();
        check_eq("t1_bin", 32'(binary_out), 32'd0);
        check_eq("t1_grant", 32'(grant_out), 32'h0001);
        check_eq("t1_multi", 32'(multi_hot), 32'd1);

        // 2. single held request re-grants
        encoder_in = 16'h0400;
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("t2_bin", 32'(binary_out), 32'hA);
            check_eq("t2_grant", 32'(grant_out), 32'h0400);
            check_eq("t2_multi", 32'(multi_hot), 32'd0);
        end

        // 3. fairness between 0 and 15
        encoder_in = 16'h8001;
        step();
        prev = binary_out;
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq("t3_alt", 32'(binary_out), (prev == 0) ? 32'd15 : 32'd0);
            check_eq("t3_multi", 32'(multi_hot), 32'd1);
            prev = binary_out;
        end

        // 4. backpressure holds index 3
        encoder_in = 16'h0008;
        step();
        check_eq("t4_bin3", 32'(binary_out), 32'd3);
        out_ready = 0; encoder_in = 16'h0100;
        for (int n = 0; n < 5; n++) begin
            step();
            check_eq("t4_hold", 32'(binary_out), 32'd3);
            check_eq("t4_hold_v", 32'(out_valid), 32'd1);
        end
        out_ready = 1;
        step();
        check_eq("t4_bin8", 32'(binary_out), 32'd8);

        // 5. wrap after index 15, then enable low
        encoder_in = 16'h8000;
        step();
        check_eq("t5_bin15", 32'(binary_out), 32'd15);
        encoder_in = 16'h0002;
        step();
        check_eq("t5_wrap", 32'(binary_out), 32'd1);
        enable = 0; encoder_in = 16'hFFFF; out_ready = 0;
        step();
        check_eq("t5_pend", 32'(out_valid), 32'd1);
        out_ready = 1;
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("t5_off", 32'(out_valid), 32'd0);
        end

        // 6. reset during a stall
        enable = 1; encoder_in = 16'h0010;
        step();
        out_ready = 0;
        step();
        check_eq("t6_stall", 32'(out_valid), 32'd1);
        reset = 1;
        step();
        check_eq("t6_rst", 32'(out_valid), 32'd0);
        reset = 0; out_ready = 1; encoder_in = 16'h8001;
        step();
        check_eq("t6_bin0", 32'(binary_out), 32'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: encoder_in = 16'($urandom);
                1: encoder_in = 16'($urandom) & 16'($urandom) & 16'($urandom);
                2: encoder_in = 16'h1 << $urandom_range(0, 15);
                default: encoder_in = 16'h0;
            endcase
            enable    = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
